// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with frame-based debounce.
// Accepted hex digits shift into a 32-bit word from the right.
module keypad_entry #(
  parameter int SCAN_DIV = 2000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [32:1] data,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HELD
  } st_t;

  st_t st, st_n;

  logic [3:0]    col_q, col_s;
  logic [CW-1:0] cnt;
  logic [1:0]    r;
  logic          slot_end, frame_end;
  logic          found, hit, f_found;
  logic [3:0]    acode, f_code;
  logic [1:0]    cidx;
  logic [3:0]    cand, cand_n;
  logic [DW-1:0] dcnt, dcnt_n, dcnt_inc;
  logic          acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_q <= col;
      col_s <= col_q;
    end
  end

  assign slot_end  = (cnt == CMAX);
  assign frame_end = slot_end && (r == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      r   <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      r   <= r + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign row = ~(4'b0001 << r);

  // lowest low column wins within a row
  always_comb begin
    cidx = 2'd0;
    priority case (1'b1)
      !col_s[0]: cidx = 2'd0;
      !col_s[1]: cidx = 2'd1;
      !col_s[2]: cidx = 2'd2;
      !col_s[3]: cidx = 2'd3;
      default:   cidx = 2'd0;
    endcase
  end

  assign hit     = slot_end && (col_s != 4'hF);
  assign f_found = found | hit;
  assign f_code  = found ? acode : {r, cidx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found <= 1'b0;
      acode <= '0;
    end else if (frame_end) begin
      found <= 1'b0;
      acode <= '0;
    end else if (hit && !found) begin
      found <= 1'b1;
      acode <= {r, cidx};
    end
  end

  assign dcnt_inc = dcnt + DW'(1);

  always_comb begin
    st_n   = st;
    cand_n = cand;
    dcnt_n = dcnt;
    acc    = 1'b0;
    if (frame_end) begin
      unique case (st)
        IDLE: begin
          if (f_found) begin
            cand_n = f_code;
            if (DEBOUNCE == 1) begin
              acc    = 1'b1;
              st_n   = HELD;
              dcnt_n = '0;
            end else begin
              st_n   = CAND;
              dcnt_n = DW'(1);
            end
          end
        end
        CAND: begin
          if (f_found && f_code == cand) begin
            if (dcnt_inc == DMAX) begin
              acc    = 1'b1;
              st_n   = HELD;
              dcnt_n = '0;
            end else begin
              dcnt_n = dcnt_inc;
            end
          end else begin
            st_n   = IDLE;
            dcnt_n = '0;
          end
        end
        HELD: begin
          if (f_found) begin
            dcnt_n = '0;
          end else if (dcnt_inc == DMAX) begin
            st_n   = IDLE;
            dcnt_n = '0;
          end else begin
            dcnt_n = dcnt_inc;
          end
        end
        default: begin
          st_n   = IDLE;
          dcnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cand      <= '0;
      dcnt      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      data      <= '0;
    end else begin
      st        <= st_n;
      cand      <= cand_n;
      dcnt      <= dcnt_n;
      key_valid <= acc;
      if (acc)
        key_code <= cand_n;
      if (clr)
        data <= '0;
      else if (acc)
        data <= {data[28:1], cand_n};
    end
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces key presses, and assembles accepted hex digits into a 32-bit word. This is the input-side counterpart of the 8-digit seven-segment scan display. `data` drives the display's 32-bit data input directly, so typed digits scroll in from the right.

## Interface

Parameters:
- SCAN_DIV, 2000, clocks spent driving each row; must be ≥ 4.
- DEBOUNCE, 4, consecutive agreeing scan frames required to accept a press or a release; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- col  input  [3:0]  keypad column lines, active-low (pulled up externally), asynchronous to clk.
- clr  input  1  synchronous clear of `data`.
- row  output  [3:0]  keypad row drive, active-low one-hot.
- data  output  [32:1]  entered word; data[4:1] is the most recent digit.
- key_code  output  [3:0]  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.

## Operation

**Column synchronizer**
- `col` passes through a 2-flop synchronizer. Only the synchronized value `col_s` is used.

**Row scan**
- Slot counter `cnt` runs 0..SCAN_DIV-1. Row index `r` runs 0..3 and advances when `cnt` = SCAN_DIV-1, wrapping 3 → 0.
- row = ~(4'b0001 << r); row 0 is 4'b1110.
- Sample point: the last cycle of each slot (`cnt` = SCAN_DIV-1), using `col_s`.
- Frame: the four slots r = 0..3. Frame end is r = 3 and `cnt` = SCAN_DIV-1.

**Per-frame detection**
- The frame accumulator (found flag and code) clears at frame start.
- At a sample point, if found = 0 and `col_s` ≠ 4'b1111: set found = 1, code = {r[1:0], c[1:0]}, where c is the lowest index with col_s[c] = 0.
- The first detected key in scan order wins. Later keys in the same frame are ignored.
- Frame result: (found, code), evaluated at frame end.

**Debounce FSM** (evaluated only at frame end; `dcnt` is the frame counter)
- IDLE: found → CAND with cand = code, dcnt = 1. Otherwise stay.
- CAND, when found with code = cand:
  - if dcnt + 1 = DEBOUNCE → accept, go to HELD;
  - else dcnt increments.
- CAND, when not found or code ≠ cand → IDLE.
- CAND with DEBOUNCE = 1: the entry frame itself accepts, going IDLE → HELD directly.
- HELD: not found → dcnt increments; reaching DEBOUNCE → IDLE. Found → dcnt = 0, stay in HELD.
- HELD entry sets dcnt = 0.
- No auto-repeat: exactly one accept per press-release cycle.

**Accept action** (registered, visible the cycle after frame end)
- key_valid = 1 for exactly one cycle.
- key_code = cand.
- data = {data[28:1], cand}.

**Clear**
- clr = 1 in a cycle sets data = 0 on the next edge.
- If clr coincides with an accept, clr wins for `data` (data = 0). key_valid and key_code still update.

**Reset values** (applied immediately on rst, asynchronous)
- row = 4'b1110, data = 0, key_code = 0, key_valid = 0.
- State = IDLE; cnt, r, dcnt, accumulator and synchronizer all cleared (synchronizer flops to 4'b1111).
- Reset mid-press returns to IDLE. A key still held after release of reset is accepted again after DEBOUNCE frames.

## Timing

- Frame length: 4·SCAN_DIV cycles.
- Column settle window: SCAN_DIV-3 cycles after the row changes, before the synchronized sample.
- Press latency: a key stable from before the start of frame F produces key_valid in the cycle after the end of frame F+DEBOUNCE-1.
- Worst case from physical press: (DEBOUNCE+1)·4·SCAN_DIV + 3 cycles.
- Minimum gap between two accepts of the same key: DEBOUNCE release frames plus DEBOUNCE press frames.
- Outputs are all registered. There are no combinational paths from `col` or `clr` to any output.

## Test plan

Bench parameters: SCAN_DIV = 4, DEBOUNCE = 2 (frame = 16 cycles).

1. **Reset and scan sequence.** Assert rst, release it, drive col = 4'hF throughout.
   - row is 4'b1110 during reset, then steps 1110 → 1101 → 1011 → 0111, 4 cycles each, repeating.
   - key_valid never asserts; data stays 0.
2. **Single press.** Press the key at row 2, col 1 (col[1] low only while row[2] is low), hold 5 frames, then release.
   - Exactly one key_valid pulse, at the end of the 2nd full frame.
   - key_code = 4'h9; data = 32'h0000_0009.
3. **Digit entry.** Enter keys 1, 2, 3, A, B, C, D, E, F in sequence, with 3 release frames between each.
   - Final data = 32'h23AB_CDEF (the first digit has been shifted out).
4. **Bounce rejection.** Present the key in frame 1, absent in frame 2, present in frames 3–4.
   - A single accept occurs at the end of frame 4. A 1-frame glitch in HELD does not cause a second accept.
5. **Two keys and priority.** Hold keys (0,3) and (2,0) together; then separately pulse clr on the accept cycle of a later press.
   - Two keys: key_code = 4'h3 (first in scan order).
   - clr on accept: data = 0, key_valid = 1.
6. **Asynchronous reset mid-operation.** Assert rst asynchronously while in CAND, then keep the key held after reset.
   - All outputs are at reset values within the same cycle as rst.
   - The held key is re-accepted 2 frames after reset release.
